// File: rtl/eth_fcs_inserter.sv
`default_nettype none
// ============================================================================
//  Module   : eth_fcs_inserter
//  Purpose  : Transmit-path Ethernet stage. Forwards an unpadded frame
//             (DA through payload) byte by byte with zero latency. Pads short
//             frames with PAD_BYTE up to MIN_FRAME bytes, then appends the
//             4-byte IEEE 802.3 FCS, least-significant byte first.
//  Ports    : clk             - single rising-edge clock
//             sreset          - synchronous, active-high reset
//             axis_i_tready   - input ready (o)
//             axis_i_tvalid   - input valid (i)
//             axis_i_tlast    - last byte of the unpadded frame (i)
//             axis_i_tdata    - input frame byte (i)
//             axis_o_tready   - output ready (i)
//             axis_o_tvalid   - output valid (o)
//             axis_o_tlast    - asserted only on the final FCS byte (o)
//             axis_o_tdata    - output byte (o)
//  Revision : 1.0 - initial release
// ============================================================================
module eth_fcs_inserter #(
    parameter int         MIN_FRAME = 60,     // 0..255 bytes before the FCS
    parameter logic [7:0] PAD_BYTE  = 8'h00
) (
    input  logic       clk,
    input  logic       sreset,
    output logic       axis_i_tready,
    input  logic       axis_i_tvalid,
    input  logic       axis_i_tlast,
    input  logic [7:0] axis_i_tdata,
    input  logic       axis_o_tready,
    output logic       axis_o_tvalid,
    output logic       axis_o_tlast,
    output logic [7:0] axis_o_tdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Nine bits so that "count + 1" never wraps when compared to the minimum.
    localparam logic [8:0]  c_min_frame = 9'(MIN_FRAME);
    // Reflected form of polynomial 0x04C11DB7.
    localparam logic [31:0] c_poly_rev  = 32'hEDB8_8320;
    localparam logic [31:0] c_crc_init  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_PAD  = 2'd1,
        ST_FCS  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [7:0]  cnt_q,   cnt_d;     // bytes sent so far, saturates at MIN_FRAME
    logic [1:0]  k_q,     k_d;       // FCS byte index
    logic [31:0] crc_q,   crc_d;     // reflected CRC register

    logic        w_xfer;
    logic [8:0]  w_cnt_inc;
    logic [31:0] w_fcs;

    // ------------------------------------------------------------------------
    // One byte of reflected CRC-32. Each data bit enters LSB first and is
    // folded into the feedback term of a right-shifting LFSR, which is the
    // same as XOR-ing the whole byte into the low bits up front.
    // ------------------------------------------------------------------------
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data_in);
        logic [31:0] c;
        logic [7:0]  d;
        c = crc_in;
        d = data_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[0]) begin
                c = {1'b0, c[31:1]} ^ c_poly_rev;
            end else begin
                c = {1'b0, c[31:1]};
            end
            d = {1'b0, d[7:1]};
        end
        return c;
    endfunction

    assign w_fcs     = ~crc_q;
    assign w_cnt_inc = {1'b0, cnt_q} + 9'd1;

    // ------------------------------------------------------------------------
    // Output stage. DATA is a pure combinational pass-through; PAD and FCS
    // drive constant or registered values so they stay stable under stall.
    // Reset gates the handshake outputs so nothing leaks while it is held.
    // ------------------------------------------------------------------------
    always_comb begin
        axis_i_tready = 1'b0;
        axis_o_tvalid = 1'b0;
        axis_o_tlast  = 1'b0;
        axis_o_tdata  = 8'h00;
        case (state_q)
            ST_DATA: begin
                axis_o_tvalid = axis_i_tvalid;
                axis_o_tdata  = axis_i_tdata;
                axis_i_tready = axis_o_tready;
            end
            ST_PAD: begin
                axis_o_tvalid = 1'b1;
                axis_o_tdata  = PAD_BYTE;
            end
            ST_FCS: begin
                axis_o_tvalid = 1'b1;
                axis_o_tlast  = (k_q == 2'd3);
                case (k_q)
                    2'd0:    axis_o_tdata = w_fcs[7:0];
                    2'd1:    axis_o_tdata = w_fcs[15:8];
                    2'd2:    axis_o_tdata = w_fcs[23:16];
                    default: axis_o_tdata = w_fcs[31:24];
                endcase
            end
            default: begin
                axis_o_tdata = 8'h00;
            end
        endcase
        if (sreset) begin
            axis_i_tready = 1'b0;
            axis_o_tvalid = 1'b0;
            axis_o_tlast  = 1'b0;
        end
    end

    // In DATA an output transfer is also an input transfer because ready and
    // valid are passed straight through.
    assign w_xfer = axis_o_tvalid & axis_o_tready;

    // ------------------------------------------------------------------------
    // Next-state logic. Everything holds unless a beat transfers.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        crc_d   = crc_q;
        case (state_q)
            ST_DATA: begin
                if (w_xfer) begin
                    crc_d = crc_byte(crc_q, axis_i_tdata);
                    // Saturate so long frames never wrap back into padding.
                    if ({1'b0, cnt_q} < c_min_frame) begin
                        cnt_d = w_cnt_inc[7:0];
                    end
                    if (axis_i_tlast) begin
                        // Once saturated, w_cnt_inc exceeds the minimum, so
                        // long frames fall through to FCS.
                        if (w_cnt_inc < c_min_frame) begin
                            state_d = ST_PAD;
                        end else begin
                            state_d = ST_FCS;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (w_xfer) begin
                    crc_d = crc_byte(crc_q, PAD_BYTE);
                    cnt_d = w_cnt_inc[7:0];
                    if (w_cnt_inc == c_min_frame) begin
                        state_d = ST_FCS;
                    end
                end
            end
            ST_FCS: begin
                // CRC is frozen here so all four FCS bytes come from one value.
                if (w_xfer) begin
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d = ST_DATA;
                        cnt_d   = 8'd0;
                        crc_d   = c_crc_init;
                    end
                end
            end
            default: begin
                state_d = ST_DATA;
                cnt_d   = 8'd0;
                k_d     = 2'd0;
                crc_d   = c_crc_init;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q <= ST_DATA;
            cnt_q   <= 8'd0;
            k_q     <= 2'd0;
            crc_q   <= c_crc_init;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            crc_q   <= crc_d;
        end
    end

endmodule
`default_nettype wire
